spi_slave_drive: RTL

//  SPI mode-0 slave (CPOL=0, CPHA=0), MSB first, for the far end of our SPI master links.

---
 rtl/spi_slave_drive_pkg.sv | 16 +
 rtl/spi_sync_edge.sv | 39 +++
 rtl/spi_slave_drive.sv | 113 +++++++++++
 3 files changed

// File: rtl/spi_slave_drive_pkg.sv
// Shared definitions for the mode-0 SPI slave.
//  SPI_DATA_W  default word width
//  SCLK_IDLE, CS_IDLE, DATA_IDLE  mode-0 idle levels of the SPI pins
//  bit_cnt_width()  width of a counter that can hold 0..w
package spi_slave_drive_pkg;

  localparam int   SPI_DATA_W = 8;
  localparam logic SCLK_IDLE  = 1'b0;
  localparam logic CS_IDLE    = 1'b1;
  localparam logic DATA_IDLE  = 1'b0;

  function automatic int bit_cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with edge detect for one asynchronous pin.
//  sys_clk, sys_rst_n  system clock, async active-low reset
//  din                 asynchronous pin level
//  lvl                 synchronized level
//  rise, fall          1-cycle pulses on synchronized level changes
// The chain and the delayed copy reset to RST_VAL so that leaving reset
// with the pin at its idle level produces no spurious edge.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   lvl_p1;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_pipe <= {SYNC_STAGES{RST_VAL}};
      lvl_p1    <= RST_VAL;
    end else begin
      // synchronizer stages: pin -> sync_pipe[SYNC_STAGES-1]
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], din};
      // one-cycle-delayed copy for edge compare
      lvl_p1    <= sync_pipe[SYNC_STAGES-1];
    end
  end

  assign lvl  = sync_pipe[SYNC_STAGES-1];
  assign rise = lvl & ~lvl_p1;
  assign fall = ~lvl & lvl_p1;

endmodule

// File: rtl/spi_slave_drive.sv
// SPI mode-0 slave (CPOL=0, CPHA=0), MSB first, oversampled on sys_clk.
//  sys_clk, sys_rst_n  system clock, async active-low reset
//  data_send           word to transmit, captured on tx_load
//  data_rec            last complete received word
//  rec_done            1-cycle pulse after data_rec is updated
//  tx_load             1-cycle pulse when data_send enters the tx shifter
//  busy                synchronized chip select active
//  spi_sclk, spi_cs, spi_mosi  SPI pins from the master (asynchronous)
//  spi_miso            serial data to the master, 0 while deselected
module spi_slave_drive
  import spi_slave_drive_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] data_send,
  output logic [DATA_W-1:0] data_rec,
  output logic              rec_done,
  output logic              tx_load,
  output logic              busy,
  input  logic              spi_sclk,
  input  logic              spi_cs,
  input  logic              spi_mosi,
  output logic              spi_miso
);

  localparam int               CNT_W    = bit_cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic cs_lvl_unused, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(SCLK_IDLE)) u_sclk_sync (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .din(spi_sclk),
    .lvl(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(CS_IDLE)) u_cs_sync (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .din(spi_cs),
    .lvl(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(DATA_IDLE)) u_mosi_sync (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .din(spi_mosi),
    .lvl(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_shift, rx_next;
  logic [DATA_W-1:0] tx_shift;
  logic              rec_pend_p0;

  // Shift the whole register so every bit is consumed; the MSB falls off.
  always_comb begin
    rx_next = (rx_shift << 1) | {{(DATA_W-1){1'b0}}, mosi_lvl};
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      busy        <= 1'b0;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      data_rec    <= '0;
      rec_pend_p0 <= 1'b0;
      rec_done    <= 1'b0;
      tx_load     <= 1'b0;
      spi_miso    <= 1'b0;
    end else begin
      tx_load     <= 1'b0;
      rec_pend_p0 <= 1'b0;
      // word completed last cycle -> announce it now
      rec_done    <= rec_pend_p0;

      // CS rise has priority over any SCLK edge in the same cycle.
      if (cs_rise) begin
        busy     <= 1'b0;
        spi_miso <= 1'b0;
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (cs_fall) begin
        busy     <= 1'b1;
        bit_cnt  <= '0;
        tx_shift <= data_send;
        tx_load  <= 1'b1;
        spi_miso <= data_send[DATA_W-1];
      end else if (busy && sclk_rise) begin
        rx_shift <= rx_next;
        if (bit_cnt == LAST_BIT) begin
          data_rec    <= rx_next;
          rec_pend_p0 <= 1'b1;
          bit_cnt     <= '0;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end else if (busy && sclk_fall) begin
        if (bit_cnt != '0) begin
          tx_shift <= tx_shift << 1;
          spi_miso <= tx_shift[DATA_W-2];
        end else begin
          // word boundary: next word goes out MSB first
          tx_shift <= data_send;
          tx_load  <= 1'b1;
          spi_miso <= data_send[DATA_W-1];
        end
      end
    end
  end

endmodule
